// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding muxes feeding the ALU, store data and EX/MEM.
// Optional feature macro: FORWARDING_EN (MEM/WB bypass). When undefined, operands come from the regfile only.
module id_ex_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_stall,
  input  logic            i_flush,
  input  logic            i_valid_d,
  input  logic [XLEN-1:0] i_pc_d,
  input  logic [XLEN-1:0] i_rs1_data_d,
  input  logic [XLEN-1:0] i_rs2_data_d,
  input  logic [XLEN-1:0] i_imm_d,
  input  logic [4:0]      i_rs1_d,
  input  logic [4:0]      i_rs2_d,
  input  logic [4:0]      i_rd_d,
  input  logic [3:0]      i_alu_control_d,
  input  logic [1:0]      i_alu_src_d,
  input  logic [6:0]      i_ctrl_d,
  input  logic [4:0]      i_rd_m,
  input  logic            i_reg_write_m,
  input  logic [XLEN-1:0] i_alu_result_m,
  input  logic [4:0]      i_rd_w,
  input  logic            i_reg_write_w,
  input  logic [XLEN-1:0] i_result_w,
  output logic            o_valid_e,
  output logic [XLEN-1:0] o_pc_e,
  output logic [XLEN-1:0] o_alu_a,
  output logic [XLEN-1:0] o_alu_b,
  output logic [3:0]      o_alu_control_e,
  output logic [XLEN-1:0] o_store_data_e,
  output logic [4:0]      o_rd_e,
  output logic [6:0]      o_ctrl_e,
  output logic [3:0]      o_fwd_sel
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [3:0]      alu_control;
    logic [1:0]      alu_src;
    logic [6:0]      ctrl;
  } ex_regs_t;

  ex_regs_t        r_ex;
  ex_regs_t        w_ex_next;
  logic [1:0]      w_fwd_a;
  logic [1:0]      w_fwd_b;
  logic [XLEN-1:0] w_rs1_fwd;
  logic [XLEN-1:0] w_rs2_fwd;

  // A bubble is all zeros; valid_d = 0 on a load is treated exactly like flush.
  always_comb begin
    w_ex_next = r_ex;
    if (i_flush) begin
      w_ex_next = '0;
    end else if (!i_stall) begin
      if (i_valid_d) begin
        w_ex_next.valid       = 1'b1;
        w_ex_next.pc          = i_pc_d;
        w_ex_next.rs1_data    = i_rs1_data_d;
        w_ex_next.rs2_data    = i_rs2_data_d;
        w_ex_next.imm         = i_imm_d;
        w_ex_next.rs1         = i_rs1_d;
        w_ex_next.rs2         = i_rs2_d;
        w_ex_next.rd          = i_rd_d;
        w_ex_next.alu_control = i_alu_control_d;
        w_ex_next.alu_src     = i_alu_src_d;
        w_ex_next.ctrl        = i_ctrl_d;
      end else begin
        w_ex_next = '0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ex <= '0;
    end else begin
      r_ex <= w_ex_next;
    end
  end

`ifdef FORWARDING_EN
  // MEM is checked first so the younger result wins; x0 is never bypassed.
  always_comb begin
    w_fwd_a = 2'b00;
    w_fwd_b = 2'b00;
    if (i_reg_write_m && (i_rd_m == r_ex.rs1) && (r_ex.rs1 != 5'd0)) begin
      w_fwd_a = 2'b10;
    end else if (i_reg_write_w && (i_rd_w == r_ex.rs1) && (r_ex.rs1 != 5'd0)) begin
      w_fwd_a = 2'b01;
    end
    if (i_reg_write_m && (i_rd_m == r_ex.rs2) && (r_ex.rs2 != 5'd0)) begin
      w_fwd_b = 2'b10;
    end else if (i_reg_write_w && (i_rd_w == r_ex.rs2) && (r_ex.rs2 != 5'd0)) begin
      w_fwd_b = 2'b01;
    end
  end
`else
  logic w_unused;
  assign w_unused = ^{i_rd_m, i_reg_write_m, i_alu_result_m, i_rd_w, i_reg_write_w,
                      i_result_w, r_ex.rs1, r_ex.rs2};
  assign w_fwd_a  = 2'b00;
  assign w_fwd_b  = 2'b00;
`endif

  always_comb begin
    w_rs1_fwd = r_ex.rs1_data;
    w_rs2_fwd = r_ex.rs2_data;
    unique case (w_fwd_a)
      2'b10:   w_rs1_fwd = i_alu_result_m;
      2'b01:   w_rs1_fwd = i_result_w;
      default: w_rs1_fwd = r_ex.rs1_data;
    endcase
    unique case (w_fwd_b)
      2'b10:   w_rs2_fwd = i_alu_result_m;
      2'b01:   w_rs2_fwd = i_result_w;
      default: w_rs2_fwd = r_ex.rs2_data;
    endcase
  end

  assign o_valid_e       = r_ex.valid;
  assign o_pc_e          = r_ex.pc;
  assign o_alu_a         = r_ex.alu_src[1] ? r_ex.pc : w_rs1_fwd;
  assign o_alu_b         = r_ex.alu_src[0] ? r_ex.imm : w_rs2_fwd;
  assign o_alu_control_e = r_ex.alu_control;
  assign o_store_data_e  = w_rs2_fwd;
  assign o_rd_e          = r_ex.rd;
  assign o_ctrl_e        = r_ex.ctrl;
  assign o_fwd_sel       = {w_fwd_b, w_fwd_a};

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed, table-driven bench for id_ex_stage; expectations follow FORWARDING_EN if defined.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush, valid_d;
  logic [31:0] pc_d, rs1_data_d, rs2_data_d, imm_d;
  logic [4:0]  rs1_d, rs2_d, rd_d;
  logic [3:0]  alu_control_d;
  logic [1:0]  alu_src_d;
  logic [6:0]  ctrl_d;
  logic [4:0]  rd_m, rd_w;
  logic        reg_write_m, reg_write_w;
  logic [31:0] alu_result_m, result_w;
  logic        valid_e;
  logic [31:0] pc_e, alu_a, alu_b, store_data_e;
  logic [3:0]  alu_control_e, fwd_sel;
  logic [4:0]  rd_e;
  logic [6:0]  ctrl_e;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_flush(flush), .i_valid_d(valid_d),
    .i_pc_d(pc_d), .i_rs1_data_d(rs1_data_d), .i_rs2_data_d(rs2_data_d), .i_imm_d(imm_d),
    .i_rs1_d(rs1_d), .i_rs2_d(rs2_d), .i_rd_d(rd_d), .i_alu_control_d(alu_control_d),
    .i_alu_src_d(alu_src_d), .i_ctrl_d(ctrl_d), .i_rd_m(rd_m), .i_reg_write_m(reg_write_m),
    .i_alu_result_m(alu_result_m), .i_rd_w(rd_w), .i_reg_write_w(reg_write_w),
    .i_result_w(result_w), .o_valid_e(valid_e), .o_pc_e(pc_e), .o_alu_a(alu_a),
    .o_alu_b(alu_b), .o_alu_control_e(alu_control_e), .o_store_data_e(store_data_e),
    .o_rd_e(rd_e), .o_ctrl_e(ctrl_e), .o_fwd_sel(fwd_sel)
  );

  typedef struct {
    logic        valid, stall, flush;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  aluc;
    logic [1:0]  src;
    logic [6:0]  ctrl;
    logic [4:0]  rd_m, rd_w;
    logic        rw_m, rw_w;
    logic [31:0] res_m, res_w;
    logic        e_valid;
    logic [31:0] e_pc, e_a, e_b, e_store;
    logic [3:0]  e_aluc, e_fwd;
    logic [4:0]  e_rd;
    logic [6:0]  e_ctrl;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic [31:0] pc, rs1d, rs2d, imm,
                              input logic [4:0] rs1, rs2, rd, input logic [3:0] aluc,
                              input logic [1:0] src, input logic [6:0] ctrl);
    vec_t v;
    v = '{default: '0};
    v.valid = 1'b1; v.pc = pc; v.rs1d = rs1d; v.rs2d = rs2d; v.imm = imm;
    v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.aluc = aluc; v.src = src; v.ctrl = ctrl;
    return v;
  endfunction

  function automatic vec_t ex(input vec_t vi, input logic valid, input logic [31:0] pc, a, b,
                              input logic [3:0] aluc, input logic [31:0] store,
                              input logic [4:0] rd, input logic [6:0] ctrl,
                              input logic [3:0] fwd);
    vec_t v;
    v = vi;
    v.e_valid = valid; v.e_pc = pc; v.e_a = a; v.e_b = b; v.e_aluc = aluc;
    v.e_store = store; v.e_rd = rd; v.e_ctrl = ctrl; v.e_fwd = fwd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    valid_d = v.valid; stall = v.stall; flush = v.flush;
    pc_d = v.pc; rs1_data_d = v.rs1d; rs2_data_d = v.rs2d; imm_d = v.imm;
    rs1_d = v.rs1; rs2_d = v.rs2; rd_d = v.rd; alu_control_d = v.aluc;
    alu_src_d = v.src; ctrl_d = v.ctrl;
    rd_m = v.rd_m; reg_write_m = v.rw_m; alu_result_m = v.res_m;
    rd_w = v.rd_w; reg_write_w = v.rw_w; result_w = v.res_w;
  endtask

  task automatic check_all(input string tag, input vec_t v);
    chk({tag, ".valid_e"}, {31'd0, valid_e}, {31'd0, v.e_valid});
    chk({tag, ".pc_e"}, pc_e, v.e_pc);
    chk({tag, ".alu_a"}, alu_a, v.e_a);
    chk({tag, ".alu_b"}, alu_b, v.e_b);
    chk({tag, ".alu_control_e"}, {28'd0, alu_control_e}, {28'd0, v.e_aluc});
    chk({tag, ".store_data_e"}, store_data_e, v.e_store);
    chk({tag, ".rd_e"}, {27'd0, rd_e}, {27'd0, v.e_rd});
    chk({tag, ".ctrl_e"}, {25'd0, ctrl_e}, {25'd0, v.e_ctrl});
    chk({tag, ".fwd_sel"}, {28'd0, fwd_sel}, {28'd0, v.e_fwd});
  endtask

  vec_t v, zero;

  initial begin
    zero = '{default: '0};
    // v0: plain register-file operands
    v = mk(32'h100, 32'h11, 32'h22, 32'h5, 5'd1, 5'd2, 5'd3, 4'd0, 2'b00, 7'b0000001);
    tv.push_back(ex(v, 1, 32'h100, 32'h11, 32'h22, 4'd0, 32'h22, 5'd3, 7'b0000001, 4'b0000));
    // v1: MEM forward on rs1 with immediate B
    v = mk(32'h104, 32'h99, 32'h77, 32'h4, 5'd5, 5'd6, 5'd8, 4'd2, 2'b01, 7'b0000001);
    v.rd_m = 5'd5; v.rw_m = 1; v.res_m = 32'h1234;
`ifdef FORWARDING_EN
    tv.push_back(ex(v, 1, 32'h104, 32'h1234, 32'h4, 4'd2, 32'h77, 5'd8, 7'b0000001, 4'b0010));
`else
    tv.push_back(ex(v, 1, 32'h104, 32'h99, 32'h4, 4'd2, 32'h77, 5'd8, 7'b0000001, 4'b0000));
`endif
    // v2: rs2 matches both MEM and WB
    v = mk(32'h108, 32'h1, 32'h2222, 32'h0, 5'd1, 5'd7, 5'd9, 4'd1, 2'b00, 7'b0000000);
    v.rd_m = 5'd7; v.rw_m = 1; v.res_m = 32'hAAAA;
    v.rd_w = 5'd7; v.rw_w = 1; v.res_w = 32'hBBBB;
`ifdef FORWARDING_EN
    tv.push_back(ex(v, 1, 32'h108, 32'h1, 32'hAAAA, 4'd1, 32'hAAAA, 5'd9, 7'd0, 4'b1000));
`else
    tv.push_back(ex(v, 1, 32'h108, 32'h1, 32'h2222, 4'd1, 32'h2222, 5'd9, 7'd0, 4'b0000));
`endif
    // v3: x0 never forwarded
    v = mk(32'h10C, 32'h30, 32'h0, 32'h0, 5'd2, 5'd0, 5'd4, 4'd0, 2'b00, 7'b0000001);
    v.rd_m = 5'd0; v.rw_m = 1; v.res_m = 32'h5555;
    v.rd_w = 5'd0; v.rw_w = 1; v.res_w = 32'h6666;
    tv.push_back(ex(v, 1, 32'h10C, 32'h30, 32'h0, 4'd0, 32'h0, 5'd4, 7'b0000001, 4'b0000));
    // v4: store data forwarded from WB while B uses the immediate
    v = mk(32'h110, 32'h40, 32'h50, 32'h8, 5'd4, 5'd3, 5'd0, 4'd0, 2'b01, 7'b0000010);
    v.rd_w = 5'd3; v.rw_w = 1; v.res_w = 32'hDEAD;
`ifdef FORWARDING_EN
    tv.push_back(ex(v, 1, 32'h110, 32'h40, 32'h8, 4'd0, 32'hDEAD, 5'd0, 7'b0000010, 4'b0100));
`else
    tv.push_back(ex(v, 1, 32'h110, 32'h40, 32'h8, 4'd0, 32'h50, 5'd0, 7'b0000010, 4'b0000));
`endif
    // v5: MEM not writing, WB supplies rs1
    v = mk(32'h114, 32'h60, 32'hA0, 32'h0, 5'd6, 5'd10, 5'd11, 4'd3, 2'b00, 7'b0000001);
    v.rd_m = 5'd6; v.rw_m = 0; v.res_m = 32'h1111;
    v.rd_w = 5'd6; v.rw_w = 1; v.res_w = 32'h2222;
`ifdef FORWARDING_EN
    tv.push_back(ex(v, 1, 32'h114, 32'h2222, 32'hA0, 4'd3, 32'hA0, 5'd11, 7'b0000001, 4'b0001));
`else
    tv.push_back(ex(v, 1, 32'h114, 32'h60, 32'hA0, 4'd3, 32'hA0, 5'd11, 7'b0000001, 4'b0000));
`endif
    // v6: AUIPC, A = pc, B = imm
    v = mk(32'h2000, 32'h0, 32'h0, 32'h1000, 5'd0, 5'd0, 5'd5, 4'd0, 2'b11, 7'b0000001);
    tv.push_back(ex(v, 1, 32'h2000, 32'h2000, 32'h1000, 4'd0, 32'h0, 5'd5, 7'b0000001, 4'b0));
    // v7: valid_d = 0 loads a bubble
    v = mk(32'h300, 32'hFF, 32'hEE, 32'h7, 5'd1, 5'd2, 5'd4, 4'd5, 2'b11, 7'b1111111);
    v.valid = 0;
    tv.push_back(ex(v, 0, 32'h0, 32'h0, 32'h0, 4'd0, 32'h0, 5'd0, 7'd0, 4'b0000));
    // v8: load a branch-like op
    v = mk(32'h400, 32'h123, 32'h456, 32'h10, 5'd11, 5'd12, 5'd13, 4'd9, 2'b00, 7'b1000001);
    tv.push_back(ex(v, 1, 32'h400, 32'h123, 32'h456, 4'd9, 32'h456, 5'd13, 7'b1000001, 4'b0));
    // v9: stall holds v8 despite new inputs
    v = mk(32'h500, 32'h1, 32'h2, 32'h3, 5'd1, 5'd2, 5'd3, 4'd4, 2'b11, 7'b0111110);
    v.stall = 1;
    tv.push_back(ex(v, 1, 32'h400, 32'h123, 32'h456, 4'd9, 32'h456, 5'd13, 7'b1000001, 4'b0));
    // v10: stall + flush together gives a bubble
    v = mk(32'h500, 32'h1, 32'h2, 32'h3, 5'd1, 5'd2, 5'd3, 4'd4, 2'b11, 7'b0111110);
    v.stall = 1; v.flush = 1;
    tv.push_back(ex(v, 0, 32'h0, 32'h0, 32'h0, 4'd0, 32'h0, 5'd0, 7'd0, 4'b0000));
    // v11: reload, then v12: flush alone
    v = mk(32'h600, 32'h31, 32'h32, 32'h33, 5'd14, 5'd15, 5'd16, 4'd6, 2'b00, 7'b0010101);
    tv.push_back(ex(v, 1, 32'h600, 32'h31, 32'h32, 4'd6, 32'h32, 5'd16, 7'b0010101, 4'b0));
    v.flush = 1;
    tv.push_back(ex(v, 0, 32'h0, 32'h0, 32'h0, 4'd0, 32'h0, 5'd0, 7'd0, 4'b0000));

    drive(zero);
    rst = 1'b1;
    #12;
    check_all("reset", ex(zero, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i]);
      tick();
      check_all($sformatf("v%0d", i), tv[i]);
    end

    // Three stalled cycles keep outputs constant.
    v = mk(32'h700, 32'h7, 32'h8, 32'h9, 5'd17, 5'd18, 5'd19, 4'd7, 2'b00, 7'b0001001);
    drive(v);
    tick();
    v = ex(v, 1, 32'h700, 32'h7, 32'h8, 4'd7, 32'h8, 5'd19, 7'b0001001, 4'b0);
    check_all("stall0", v);
    for (int k = 1; k <= 3; k++) begin
      stall = 1'b1; pc_d = 32'h900 + k; rs1_data_d = 32'hF0 + k; rd_d = 5'd1;
      tick();
      check_all($sformatf("stall%0d", k), v);
    end
    stall = 1'b0;

    // Asynchronous reset mid-cycle clears immediately with valid_d still high.
    valid_d = 1'b1; pc_d = 32'h800;
    #3;
    rst = 1'b1;
    #1;
    check_all("async_rst", ex(zero, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;
    pc_d = 32'h100; rs1_data_d = 32'h0; rs2_data_d = 32'h0; alu_src_d = 2'b00;
    tick();
    chk("post_rst.pc_e", pc_e, 32'h100);
    chk("post_rst.valid_e", {31'd0, valid_e}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register and operand-select front end of the execute stage in the 5-stage RISC-V pipeline. It captures decoded instruction fields on each clock, supports stall and flush, and drives the ALU's A, B and 4-bit control inputs. It also drives forwarded store data and the control bundle consumed by EX/MEM. Operands are resolved from the register file, the MEM stage or the WB stage by the forwarding muxes.

## Interface
- XLEN, 32, datapath width.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold all registered fields.
- flush  in  1  load a bubble.
- valid_d  in  1  decode slot holds a real instruction.
- pc_d  in  XLEN  instruction PC.
- rs1_data_d, rs2_data_d  in  XLEN  register-file read data.
- imm_d  in  XLEN  sign-extended immediate.
- rs1_d, rs2_d, rd_d  in  5 each  register indices.
- alu_control_d  in  4  ALU op (0000 ADD … 1001 SLTU).
- alu_src_d  in  2  {a_is_pc, b_is_imm}.
- ctrl_d  in  7  {jump, branch, result_src[1:0], mem_read, mem_write, reg_write}.
- rd_m, reg_write_m, alu_result_m  in  5/1/XLEN  MEM-stage forward source.
- rd_w, reg_write_w, result_w  in  5/1/XLEN  WB-stage forward source.
- valid_e  out  1  execute slot valid.
- pc_e  out  XLEN  registered PC, for the branch target.
- alu_a, alu_b  out  XLEN  ALU operands.
- alu_control_e  out  4  registered ALU op.
- store_data_e  out  XLEN  forwarded rs2 value.
- rd_e  out  5  destination index.
- ctrl_e  out  7  registered control bundle.
- fwd_sel  out  4  {fwd_b[1:0], fwd_a[1:0]}: 00 = register file, 10 = MEM, 01 = WB.

## Operation
- Register update, in priority order: rst, then flush, then stall, then load from the *_d inputs.
- Bubble (flush):
  - valid_e, ctrl_e, rd_e, alu_control_e, rs1/rs2 indices and alu_src are 0.
  - Data fields (pc, rs1/rs2 data, imm) are 0.
- Stall holds every register, including valid_e.
- flush and stall asserted together: flush wins.
- If valid_d = 0 on a load, the register captures a bubble, identical to flush.
- Forward select per source operand s (rs1 or rs2, using its registered index rsN_e):
  - MEM when reg_write_m = 1, rd_m = rsN_e and rsN_e ≠ 0.
  - Otherwise WB when reg_write_w = 1, rd_w = rsN_e and rsN_e ≠ 0.
  - Otherwise the registered rsN data.
  - MEM has priority over WB when both match.
  - Index x0 is never forwarded.
- alu_a = a_is_pc ? pc_e : forwarded rs1.
- alu_b = b_is_imm ? imm_e : forwarded rs2.
- store_data_e is always the forwarded rs2 value, regardless of b_is_imm.
- Load-use hazards are not detected here. The hazard unit asserts stall upstream and flush here.

## Timing
- On rst, every register and output is 0:
  - alu_control_e = ADD, so the ALU computes 0 + 0 and raises zero.
  - fwd_sel = 0000, unless a forwarding match exists on the rd_m/rd_w inputs.
- Register latency is 1 cycle: *_d inputs sampled at edge n appear on *_e outputs after edge n.
- Forward muxes and alu_a/alu_b/store_data_e are combinational from the registers and the MEM/WB inputs, with no added cycle. This path must close timing together with the ALU in one cycle.
- Reset asserted mid-stream clears the held instruction immediately, without waiting for a clock edge. On release, the register loads on the next edge.

## Configuration
- FORWARDING_EN defined: forwarding behaves as above.
- FORWARDING_EN undefined:
  - fwd_sel is tied to 0000 and operands come only from the registered register-file data.
  - The MEM/WB inputs are ignored.
  - The hazard unit must stall on every RAW dependency.

## Test plan
- Reset: assert rst mid-run with valid_d = 1 → all outputs 0 and valid_e = 0 immediately; first edge after release loads pc_d = 0x100.
- MEM forward: rs1_e = 5, rd_m = 5, reg_write_m = 1, alu_result_m = 0x1234, b_is_imm = 1, imm = 4 → fwd_sel = 0010, alu_a = 0x1234, alu_b = 4.
- Priority and x0:
  - rs2_e = 7 matches both MEM (0xAAAA) and WB (0xBBBB) → alu_b = store_data_e = 0xAAAA.
  - rs2_e = 0 with rd_m = 0 and reg_write_m = 1 → no forward, alu_b = 0.
- Store forward with immediate: rs2_e = 3, rd_w = 3, result_w = 0xDEAD, b_is_imm = 1 → alu_b = imm, store_data_e = 0xDEAD, fwd_b = 01.
- Stall/flush:
  - stall for 3 cycles → outputs constant.
  - stall and flush asserted together → bubble, with valid_e = 0 and ctrl_e = 0.
- AUIPC path: a_is_pc = 1, pc_d = 0x2000, imm = 0x1000 → alu_a = 0x2000, alu_b = 0x1000 one cycle later.
